// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM states, requester ids
// and the round-robin pick used when both requesters ask in the same cycle.
package ram_arbiter_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } arb_state_e;

  // Requester ids, also the encoding of the grant and last-grant registers
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // A lone requester always wins; on a tie the one not granted last time wins
  function automatic logic rr_pick(logic a_req, logic b_req, logic last);
    if (a_req && b_req) begin
      return (last == REQ_A) ? REQ_B : REQ_A;
    end
    return a_req ? REQ_A : REQ_B;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle for the arbiter: requester A and B handshakes plus the RAM port.
// slave is the arbiter's view, master is the requesters' and RAM's view.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16
) ();
  import ram_arbiter_pkg::*;

  logic                  a_req;
  logic [31:0]           a_addr;
  logic [StrbWidth-1:0]  a_we;
  logic [DataWidth-1:0]  a_wdata;
  logic                  a_ack;
  logic [DataWidth-1:0]  a_rdata;

  logic                  b_req;
  logic [31:0]           b_addr;
  logic [StrbWidth-1:0]  b_we;
  logic [DataWidth-1:0]  b_wdata;
  logic                  b_ack;
  logic [DataWidth-1:0]  b_rdata;

  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [StrbWidth-1:0]  mem_we;
  logic [DataWidth-1:0]  mem_wdata;
  logic [DataWidth-1:0]  mem_rdata;

  modport slave (
    input  a_req, a_addr, a_we, a_wdata,
    input  b_req, b_addr, b_we, b_wdata,
    input  mem_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output mem_en, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output a_req, a_addr, a_we, a_wdata,
    output b_req, b_addr, b_we, b_wdata,
    output mem_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  mem_en, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requester A (CPU data)
// and requester B (loader/DMA). Each access takes IDLE -> ISSUE -> RESP.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  arb_state_e            r_state;
  logic                  r_grant;
  logic                  r_last;
  logic                  r_mem_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [StrbWidth-1:0]  r_mem_we;
  logic [DataWidth-1:0]  r_mem_wdata;
  logic                  r_a_ack;
  logic                  r_b_ack;
  logic [DataWidth-1:0]  r_a_rdata;
  logic [DataWidth-1:0]  r_b_rdata;

  logic                  w_any;
  logic                  w_pick;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [StrbWidth-1:0]  w_we;
  logic [DataWidth-1:0]  w_wdata;
  logic                  w_a_ack;
  logic                  w_b_ack;
  logic                  w_unused;

  // Byte-offset bits and bits above the RAM range are dropped (addresses alias)
  assign w_unused = ^{bus.a_addr[31:ADDR_WIDTH+2], bus.a_addr[1:0],
                      bus.b_addr[31:ADDR_WIDTH+2], bus.b_addr[1:0]};

  // Choose the winner and mux its request fields
  always_comb begin
    w_any  = bus.a_req | bus.b_req;
    w_pick = rr_pick(bus.a_req, bus.b_req, r_last);
    if (w_pick == REQ_A) begin
      w_addr  = bus.a_addr[ADDR_WIDTH+1:2];
      w_we    = bus.a_we;
      w_wdata = bus.a_wdata;
    end else begin
      w_addr  = bus.b_addr[ADDR_WIDTH+1:2];
      w_we    = bus.b_we;
      w_wdata = bus.b_wdata;
    end
  end

  // Arbitration FSM: IDLE grants and latches, ISSUE strobes the RAM, RESP acks
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_grant     <= REQ_A;
      r_last      <= REQ_B;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= '0;
      r_mem_wdata <= '0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_grant     <= w_pick;
            r_last      <= w_pick;
            r_mem_en    <= 1'b1;
            r_mem_addr  <= w_addr;
            r_mem_we    <= w_we;
            r_mem_wdata <= w_wdata;
            r_state     <= StIssue;
          end
        end
        StIssue: begin
          r_mem_en <= 1'b0;
          r_mem_we <= '0;
          r_a_ack  <= (r_grant == REQ_A);
          r_b_ack  <= (r_grant == REQ_B);
          r_state  <= StResp;
        end
        StResp: begin
          // Keep the returned word so rdata holds until this requester's next ack
          if (r_a_ack) r_a_rdata <= bus.mem_rdata;
          if (r_b_ack) r_b_rdata <= bus.mem_rdata;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Acks are masked by rst so a reset landing in RESP cancels the completion
  assign w_a_ack = r_a_ack & ~rst;
  assign w_b_ack = r_b_ack & ~rst;

  assign bus.a_ack     = w_a_ack;
  assign bus.b_ack     = w_b_ack;
  assign bus.a_rdata   = w_a_ack ? bus.mem_rdata : r_a_rdata;
  assign bus.b_rdata   = w_b_ack ? bus.mem_rdata : r_b_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, is the number of word-address bits driven to the RAM.
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Ports a_req / b_req, input, 1: requester A (CPU data) / B (loader/DMA) requests an access.
REQ-005 Ports a_addr / b_addr, input, 32: byte address; bits [1:0] are ignored.
REQ-006 Ports a_we / b_we, input, 4: byte-lane write enables; 4'b0000 means read.
REQ-007 Ports a_wdata / b_wdata, input, 32: write data, lane-aligned.
REQ-008 Ports a_ack / b_ack, output, 1: one-cycle pulse marking access completion.
REQ-009 Ports a_rdata / b_rdata, output, 32: read data, valid in the ack cycle.
REQ-010 Port mem_en, output, 1: RAM access strobe.
REQ-011 Port mem_addr, output, ADDR_WIDTH: word address = granted addr[ADDR_WIDTH+1:2].
REQ-012 Ports mem_we (output, 4) and mem_wdata (output, 32): granted byte enables and write data.
REQ-013 Port mem_rdata, input, 32: RAM read data, one-cycle latency after mem_en.

Function
REQ-014 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-015 IDLE, no requests: stay IDLE; mem_en=0, both acks=0.
REQ-016 IDLE, one request: grant that requester, latch its addr/we/wdata, go ISSUE.
REQ-017 IDLE, both requests: grant the requester not granted last (round-robin), go ISSUE.
REQ-018 ISSUE: drive mem_en=1 and the latched mem_addr/mem_we/mem_wdata for exactly one cycle, then go RESP.
REQ-019 RESP: pulse ack of the granted requester only, and drive its rdata with mem_rdata captured in that cycle (writes return the captured word too); then go IDLE.
REQ-020 Latency from req sampled in IDLE to ack: 2 cycles; peak throughput: one access per 3 cycles.
REQ-021 The requester holds req and its signals stable until ack, and deasserts req in the cycle after ack; a req still high in IDLE is treated as a new access.
REQ-022 Request inputs SHALL NOT be sampled in ISSUE or RESP; changes there have no effect.
REQ-023 mem_we SHALL be 0 whenever mem_en=0; no write may occur outside ISSUE.
REQ-024 The last-grant register SHALL update only on a grant.
REQ-025 a_rdata/b_rdata hold their last value between acks, each updated only on its own ack.
REQ-026 Address bits above ADDR_WIDTH+1 SHALL be ignored (aliasing/wrap, no error).

Reset
REQ-027 On rst: state=IDLE; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; a_ack=b_ack=0; a_rdata=b_rdata=0; last-grant=B, so A wins the first tie.
REQ-028 Reset asserted in ISSUE or RESP SHALL abort the access: no ack is issued and no write is repeated after reset.
REQ-029 The FSM leaves IDLE no earlier than the first cycle after rst deasserts.

Structure
REQ-030 The state encoding (IDLE/ISSUE/RESP) and the requester-id constants (REQ_A, REQ_B) SHALL live in the shared SoC package.
REQ-031 The block is one module, with no sub-module; the RAM stays external and is instantiated by the SoC.

Verification
REQ-032 Read from A only: RAM word 0x401 = 0x0101_0001; a_req=1, a_addr=0x1004, a_we=0 -> mem_en in cycle +1 with mem_addr=0x401; a_ack and a_rdata=0x0101_0001 in cycle +2; b_ack stays 0.
REQ-033 Byte write from B: b_addr=0x1007, b_we=4'b1000, b_wdata=0x0100_0000 -> one mem_en cycle with mem_we=4'b1000; a later A read of 0x1004 returns 0x0101_0001 when the word was 0x0001_0001.
REQ-034 Simultaneous requests after reset: A and B request together, both held -> A is granted first, B second, A third; acks alternate and never coincide.
REQ-035 Back-to-back: A re-requests in the IDLE cycle after its ack while B is idle -> acks 3 cycles apart.
REQ-036 Reset in ISSUE during a write of 0xFFFF_FFFF to 0x1000 -> no ack; all outputs 0 in the cycle after reset; mem_en does not reassert until a new request.
REQ-037 Aliasing: a_addr=0x0004_1004 with ADDR_WIDTH=16 -> mem_addr=0x0401.
